// File: rtl/nemu_sched_pkg.sv
// Shared types and LFSR step for the NEMU destination scheduler.
// Also supplies default `PORTS / `PORT_BITS when the build does not define them.
`ifndef PORTS
`define PORTS 4
`endif
`ifndef PORT_BITS
`define PORT_BITS ((`PORTS > 1) ? $clog2(`PORTS) : 1)
`endif

package nemu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    GRANT = 2'd2
  } state_t;

  localparam int unsigned LFSR_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 8'hA5;

  function automatic logic [LFSR_W-1:0] next_lfsr(input logic [LFSR_W-1:0] r);
    return {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
  endfunction

endpackage

// File: rtl/nemu_dest_lfsr.sv
// Free-running 8-bit LFSR plus wrapping fallback counter; emits an in-range candidate destination.
module nemu_dest_lfsr
  import nemu_sched_pkg::*;
#(
  parameter int unsigned       PORTS     = `PORTS,
  parameter int unsigned       PORT_BITS = `PORT_BITS,
  parameter logic [LFSR_W-1:0] SEED      = LFSR_DEFAULT_SEED
) (
  input  logic                 i_clk,
  input  logic                 reset_n,
  output logic [PORT_BITS-1:0] o_cand
);

  // An all-zero seed would lock the LFSR up.
  localparam logic [LFSR_W-1:0]    SeedEff  = (SEED == '0) ? LFSR_DEFAULT_SEED : SEED;
  localparam logic [PORT_BITS-1:0] LastPort = PORT_BITS'(PORTS - 1);

  logic [LFSR_W-1:0]    lfsr_q;
  logic [PORT_BITS-1:0] cnt_q;
  logic [PORT_BITS-1:0] raw;

  always_ff @(posedge i_clk) begin
    if (!reset_n) begin
      lfsr_q <= SeedEff;
      cnt_q  <= '0;
    end else begin
      lfsr_q <= next_lfsr(lfsr_q);
      cnt_q  <= (cnt_q == LastPort) ? '0 : cnt_q + 1'b1;
    end
  end

  assign raw    = lfsr_q[PORT_BITS-1:0];
  assign o_cand = (32'(raw) >= PORTS) ? cnt_q : raw;

endmodule

// File: rtl/nemu_dest_scheduler.sv
// Round-robin destination scheduler: one LFSR draw per grant, IDLE -> DRAW -> GRANT.
// Define NEMU_SELF_DEST_EN to let a source be handed its own index as destination.
module nemu_dest_scheduler
  import nemu_sched_pkg::*;
#(
  parameter int unsigned       PORTS     = `PORTS,
  parameter int unsigned       PORT_BITS = `PORT_BITS,
  parameter logic [LFSR_W-1:0] SEED      = LFSR_DEFAULT_SEED
) (
  input  logic                 i_clk,
  input  logic                 reset_n,
  input  logic                 i_enable,
  input  logic [PORTS-1:0]     i_req,
  output logic [PORTS-1:0]     o_gnt,
  output logic                 o_valid,
  output logic [PORT_BITS-1:0] o_dest,
  output logic                 o_busy
);

  localparam logic [PORT_BITS-1:0] LastPort = PORT_BITS'(PORTS - 1);

  function automatic logic [PORT_BITS-1:0] wrap_inc(input logic [PORT_BITS-1:0] p);
    return (p == LastPort) ? '0 : p + 1'b1;
  endfunction

  state_t               state_q, state_d;
  logic [PORT_BITS-1:0] rr_q, rr_d;
  logic [PORT_BITS-1:0] winner_q, winner_d;
  logic [PORT_BITS-1:0] dest_q, dest_d;
  logic [PORTS-1:0]     gnt_q, gnt_d;
  logic                 valid_q, valid_d;
  logic [PORT_BITS-1:0] cand, final_dest;
  logic [PORT_BITS-1:0] pick, pick_lo, pick_hi;
  logic                 any_lo, any_hi;

  nemu_dest_lfsr #(
    .PORTS    (PORTS),
    .PORT_BITS(PORT_BITS),
    .SEED     (SEED)
  ) u_lfsr (
    .i_clk  (i_clk),
    .reset_n(reset_n),
    .o_cand (cand)
  );

  // Lowest requester at/after the pointer wins; otherwise wrap to the lowest overall.
  always_comb begin
    pick_lo = '0;
    pick_hi = '0;
    any_lo  = 1'b0;
    any_hi  = 1'b0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (i_req[i] && !any_lo) begin
        pick_lo = PORT_BITS'(i);
        any_lo  = 1'b1;
      end
      if (i_req[i] && !any_hi && (PORT_BITS'(i) >= rr_q)) begin
        pick_hi = PORT_BITS'(i);
        any_hi  = 1'b1;
      end
    end
    pick = any_hi ? pick_hi : pick_lo;
  end

  always_comb begin
    final_dest = cand;
`ifdef NEMU_SELF_DEST_EN
`else
    if (cand == winner_q) final_dest = wrap_inc(winner_q);
`endif
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    winner_d = winner_q;
    dest_d   = dest_q;
    gnt_d    = '0;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_enable && |i_req) begin
          winner_d = pick;
          state_d  = DRAW;
        end
      end
      DRAW: begin
        dest_d = final_dest;
        // Source gave up before the draw completed: abandon silently.
        if (i_req[winner_q]) begin
          gnt_d   = PORTS'(1) << winner_q;
          valid_d = 1'b1;
          state_d = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        rr_d    = wrap_inc(winner_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      winner_q <= '0;
      dest_q   <= '0;
      gnt_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      winner_q <= winner_d;
      dest_q   <= dest_d;
      gnt_q    <= gnt_d;
      valid_q  <= valid_d;
    end
  end

  assign o_gnt   = gnt_q;
  assign o_valid = valid_q;
  assign o_dest  = dest_q;
  assign o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_nemu_dest_scheduler.sv
// Self-checking bench for nemu_dest_scheduler: directed scenarios plus randomized traffic
// compared each cycle against a transaction-level reference model.
module tb_nemu_dest_scheduler;

  localparam int P = 4;

  logic       i_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       i_enable = 1'b1;
  logic [3:0] req = '0;
  logic [2:0] req3 = '0;

  logic [3:0] gnt;
  logic       valid;
  logic [1:0] dest;
  logic       busy;
  logic [2:0] gnt3;
  logic       valid3;
  logic [1:0] dest3;
  logic       busy3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 i_clk = ~i_clk;

  nemu_dest_scheduler #(.PORTS(4), .PORT_BITS(2), .SEED(8'hA5)) dut (
    .i_clk(i_clk), .reset_n(reset_n), .i_enable(i_enable), .i_req(req),
    .o_gnt(gnt), .o_valid(valid), .o_dest(dest), .o_busy(busy)
  );

  nemu_dest_scheduler #(.PORTS(3), .PORT_BITS(2), .SEED(8'hA5)) dut3 (
    .i_clk(i_clk), .reset_n(reset_n), .i_enable(i_enable), .i_req(req3),
    .o_gnt(gnt3), .o_valid(valid3), .o_dest(dest3), .o_busy(busy3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model for the 4-port instance, in terms of cycles since reset.
  int         gc = 0;
  int         k = 0;
  int         t_draw = 0;
  int         pw = 0;
  int         rr = 0;
  bit         pend = 1'b0;
  logic [7:0] m_lfsr = 8'hA5;
  logic [3:0] e_gnt = '0;
  bit         e_valid = 1'b0;
  int         e_dest = 0;
  bit         chk_en = 1'b0;

  function automatic int rr_pick(input logic [3:0] r, input int start);
    for (int j = 0; j < P; j++) if (r[(start + j) % P]) return (start + j) % P;
    return 0;
  endfunction

  function automatic int draw_dest(input logic [7:0] l, input int kk, input int w, input int np);
    int c;
    c = int'(l) % 4;
    if (c >= np) c = kk % np;
`ifndef NEMU_SELF_DEST_EN
    if (c == w) c = (w + 1) % np;
`endif
    return c;
  endfunction

  always @(posedge i_clk) begin
    int v, fb;
    if (!reset_n) begin
      pend = 1'b0; rr = 0; k = 0; m_lfsr = 8'hA5;
      e_gnt = '0; e_valid = 1'b0; e_dest = 0;
    end else begin
      e_gnt = '0;
      e_valid = 1'b0;
      if (pend && gc == t_draw) begin
        e_dest = draw_dest(m_lfsr, k, pw, P);
        if (req[pw]) begin
          e_gnt = 4'(1 << pw);
          e_valid = 1'b1;
        end else begin
          pend = 1'b0;
        end
      end else if (pend && gc == t_draw + 1) begin
        rr = (pw + 1) % P;
        pend = 1'b0;
      end else if (!pend && i_enable && req != 0) begin
        pw = rr_pick(req, rr);
        pend = 1'b1;
        t_draw = gc + 1;
      end
      v = int'(m_lfsr);
      fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
      m_lfsr = 8'(((v << 1) & 255) | fb);
      k++;
    end
    gc++;
  end

  always @(negedge i_clk) begin
    if (chk_en) begin
      check_eq("m_gnt", 32'(gnt), 32'(e_gnt));
      check_eq("m_valid", 32'(valid), 32'(e_valid));
      check_eq("m_busy", 32'(busy), 32'(pend));
      if (e_valid) check_eq("m_dest", 32'(dest), 32'(e_dest));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  // Returns inside cycle 0: the first cycle after the reset edge.
  task automatic do_reset();
    @(negedge i_clk);
    reset_n = 1'b0;
    req = '0;
    req3 = '0;
    i_enable = 1'b1;
    @(negedge i_clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [3:0] rr_exp [5];
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

    @(negedge i_clk);
    chk_en = 1'b1;
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_dest", 32'(dest), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);

    // Single requester, first draw.
    do_reset();
    req = 4'b0001;
    step(1);
    check_eq("t1_busy_draw", 32'(busy), 32'd1);
    check_eq("t1_nogrant_c1", 32'(valid), 32'd0);
    step(1);
    check_eq("t1_gnt", 32'(gnt), 32'b0001);
    check_eq("t1_valid", 32'(valid), 32'd1);
    check_eq("t1_dest", 32'(dest), 32'd2);
    req = '0;
    step(1);
    check_eq("t1_pulse", 32'(valid), 32'd0);

    // Self-destination rule.
    do_reset();
    step(1);
    req = 4'b0010;
    step(2);
    check_eq("t2_gnt", 32'(gnt), 32'b0010);
`ifdef NEMU_SELF_DEST_EN
    check_eq("t2_dest", 32'(dest), 32'd1);
`else
    check_eq("t2_dest", 32'(dest), 32'd2);
`endif
    req = '0;

    // Out-of-range fallback, PORTS=3.
    do_reset();
    step(5);
    req3 = 3'b001;
    step(2);
    check_eq("t3_gnt", 32'(gnt3), 32'b001);
    check_eq("t3_valid", 32'(valid3), 32'd1);
`ifdef NEMU_SELF_DEST_EN
    check_eq("t3_dest", 32'(dest3), 32'd0);
`else
    check_eq("t3_dest", 32'(dest3), 32'd1);
`endif
    req3 = '0;

    // All requesting: strict rotation every three cycles.
    do_reset();
    req = 4'b1111;
    for (int c = 1; c <= 15; c++) begin
      step(1);
      if (c % 3 == 2) check_eq($sformatf("t4_gnt_c%0d", c), 32'(gnt), 32'(rr_exp[c / 3]));
      else check_eq($sformatf("t4_idle_c%0d", c), 32'(gnt), 32'd0);
    end
    req = '0;

    // Request withdrawn during the draw.
    do_reset();
    req = 4'b0100;
    step(1);
    req = '0;
    step(1);
    check_eq("t5_gnt", 32'(gnt), 32'd0);
    check_eq("t5_valid", 32'(valid), 32'd0);
    check_eq("t5_busy", 32'(busy), 32'd0);

    // Reset mid-draw, then disabled arbitration.
    do_reset();
    req = 4'b0001;
    step(1);
    check_eq("t6_busy_draw", 32'(busy), 32'd1);
    reset_n = 1'b0;
    step(1);
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_gnt", 32'(gnt), 32'd0);
    check_eq("t6_valid", 32'(valid), 32'd0);
    check_eq("t6_lfsr", 32'(dut.u_lfsr.lfsr_q), 32'hA5);
    reset_n = 1'b1;
    i_enable = 1'b0;
    req = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      step(1);
      check_eq("t6_dis_busy", 32'(busy), 32'd0);
      check_eq("t6_dis_gnt", 32'(gnt), 32'd0);
    end
    req = '0;

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge i_clk);
      if (!reset_n) reset_n = 1'b1;
      else if ($urandom_range(0, 299) == 0) reset_n = 1'b0;
      i_enable = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < P; i++) begin
        if (req[i] && gnt[i]) req[i] = 1'b0;
        else if (req[i] && $urandom_range(0, 39) == 0) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
      end
    end
    step(2);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
